string_hw_engine: RTL and testbench

//  Parametrised multi-cycle string.h accelerator for the Nios II custom path. Holds two
//  MAX_CHARS-byte operand strings and walks them LANES bytes per clock, stopping early at
//  NUL. Ops: strcmp, toupper, tolower, strlen, strrev. Keeps the level go/done handshake.

---
 rtl/string_hw_engine.sv | 162 ++++++++++++++++
 tb/tb_string_hw_engine.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/string_hw_engine.sv
// Multi-cycle string accelerator: strcmp/toupper/tolower/strlen/strrev over latched
// operand buffers, LANES bytes per RUN cycle, with a level go/done handshake.
module string_hw_engine #(
    parameter int MAX_CHARS = 32,
    parameter int LANES     = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          go,
    input  logic [3:0]                    index,
    input  logic [0:MAX_CHARS-1][7:0]     A,
    input  logic [0:MAX_CHARS-1][7:0]     B,
    output logic                          busy,
    output logic                          done,
    output logic                          err,
    output logic [0:MAX_CHARS-1][7:0]     Result
);

    localparam int NCH = MAX_CHARS / LANES;
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int IW  = $clog2(MAX_CHARS);
    localparam int LB  = $clog2(LANES);

    localparam logic [3:0] OP_CMP   = 4'd0;
    localparam logic [3:0] OP_UPPER = 4'd1;
    localparam logic [3:0] OP_LOWER = 4'd2;
    localparam logic [3:0] OP_LEN   = 4'd3;
    localparam logic [3:0] OP_REV   = 4'd4;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_REV, S_DONE} state_t;

    state_t                      r_state, w_state_next;
    logic [CW-1:0]               r_chunk;
    logic [0:MAX_CHARS-1][7:0]   r_a, r_b, r_result;
    logic [3:0]                  r_op;
    logic [7:0]                  r_len;
    logic                        r_err;

    logic [IW-1:0]               w_base;
    logic [7:0]                  w_la [LANES];
    logic [7:0]                  w_lb [LANES];
    logic [7:0]                  w_up [LANES];
    logic [7:0]                  w_dn [LANES];
    logic [LANES-1:0]            w_hit;
    logic [LANES-1:0]            w_keep;
    logic                        w_found, w_last, w_term;
    logic [7:0]                  w_toff, w_ta, w_tb, w_t, w_cmp;

    assign w_base = IW'(r_chunk) << LB;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic [IW-1:0] w_idx;
            assign w_idx     = w_base + IW'(gi);
            assign w_la[gi]  = r_a[w_idx];
            assign w_lb[gi]  = r_b[w_idx];
            assign w_hit[gi] = (r_op == OP_CMP) ? ((w_la[gi] != w_lb[gi]) || (w_la[gi] == 8'h00))
                                                : (w_la[gi] == 8'h00);
            assign w_up[gi]  = (w_la[gi] >= 8'h61 && w_la[gi] <= 8'h7A) ? w_la[gi] - 8'd32 : w_la[gi];
            assign w_dn[gi]  = (w_la[gi] >= 8'h41 && w_la[gi] <= 8'h5A) ? w_la[gi] + 8'd32 : w_la[gi];
            // A lane is written when no lower lane of this chunk has already terminated.
            if (gi == 0) begin : g_first
                assign w_keep[gi] = 1'b1;
            end else begin : g_rest
                assign w_keep[gi] = ~|w_hit[gi-1:0];
            end
        end
    endgenerate

    always_comb begin
        w_found = 1'b0;
        w_toff  = 8'h00;
        w_ta    = 8'h00;
        w_tb    = 8'h00;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_found = 1'b1;
                w_toff  = 8'(i);
                w_ta    = w_la[i];
                w_tb    = w_lb[i];
            end
        end
    end

    assign w_last = (r_chunk == CW'(NCH - 1));
    assign w_term = w_found || w_last;
    assign w_t    = w_found ? (8'(w_base) + w_toff) : 8'(MAX_CHARS);
    assign w_cmp  = !w_found       ? 8'h00 :
                    (w_ta > w_tb)  ? 8'h01 :
                    (w_ta < w_tb)  ? 8'hFF : 8'h00;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (go) w_state_next = (index > OP_REV) ? S_DONE : S_RUN;
            S_RUN:  if (w_term) w_state_next = (r_op == OP_REV) ? S_REV : S_DONE;
            S_REV:  w_state_next = S_DONE;
            S_DONE: if (!go) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_chunk  <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_op     <= '0;
            r_len    <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (go) begin
                        r_a      <= A;
                        r_b      <= B;
                        r_op     <= index;
                        r_result <= '0;
                        r_err    <= (index > OP_REV);
                        r_chunk  <= '0;
                    end
                end
                S_RUN: begin
                    r_chunk <= r_chunk + CW'(1);
                    case (r_op)
                        OP_UPPER, OP_LOWER: begin
                            for (int i = 0; i < LANES; i++) begin
                                if (w_keep[i])
                                    r_result[w_base + IW'(i)] <= (r_op == OP_UPPER) ? w_up[i] : w_dn[i];
                            end
                        end
                        OP_CMP: if (w_term) r_result[0] <= w_cmp;
                        OP_LEN: if (w_term) r_result[0] <= w_t;
                        OP_REV: if (w_term) r_len <= w_t;
                        default: ;
                    endcase
                end
                S_REV: begin
                    for (int i = 0; i < MAX_CHARS; i++) begin
                        if (i < int'(r_len))
                            r_result[IW'(i)] <= r_a[IW'(int'(r_len) - 1 - i)];
                        else
                            r_result[IW'(i)] <= 8'h00;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy   = (r_state == S_RUN) || (r_state == S_REV);
    assign done   = (r_state == S_DONE);
    assign err    = r_err;
    assign Result = r_result;

endmodule

// File: tb/tb_string_hw_engine.sv
// Directed bench for string_hw_engine: LANES=4 and LANES=1 instances, hand-computed
// results and go-to-done latencies.
`timescale 1ns/1ps
module tb_string_hw_engine;

    logic                 clk;
    logic                 reset;
    logic                 go0, go1;
    logic [3:0]           index;
    logic [0:31][7:0]     A, B;
    logic                 busy0, done0, err0;
    logic                 busy1, done1, err1;
    logic [0:31][7:0]     res0, res1;

    int n_cmp = 0;
    int n_mis = 0;

    localparam logic [0:31][7:0] X32_LO = {32{8'h78}};

    string_hw_engine #(.MAX_CHARS(32), .LANES(4)) dut0 (
        .clk(clk), .reset(reset), .go(go0), .index(index), .A(A), .B(B),
        .busy(busy0), .done(done0), .err(err0), .Result(res0)
    );

    string_hw_engine #(.MAX_CHARS(32), .LANES(1)) dut1 (
        .clk(clk), .reset(reset), .go(go1), .index(index), .A(A), .B(B),
        .busy(busy1), .done(done1), .err(err1), .Result(res1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    function automatic logic [0:31][7:0] s2b(input string s);
        logic [0:31][7:0] v;
        v = '0;
        for (int i = 0; i < s.len() && i < 32; i++) v[i] = s[i];
        return v;
    endfunction

    function automatic logic [0:31][7:0] b0(input logic [7:0] b);
        logic [0:31][7:0] v;
        v = '0;
        v[0] = b;
        return v;
    endfunction

    task automatic run_op(input string tag, input bit sel, input logic [3:0] op,
                          input logic [0:31][7:0] a, input logic [0:31][7:0] b,
                          input int lat, input logic [0:31][7:0] exp_res,
                          input logic exp_err, input int hold);
        int edges;
        @(negedge clk);
        A = a; B = b; index = op;
        if (sel) go1 = 1'b1; else go0 = 1'b1;
        edges = 0;
        do begin
            @(posedge clk); #1;
            edges++;
            if (edges == 1) begin
                // scramble inputs; the engine must work from its latched copies
                A = ~a; B = ~b; index = 4'hF;
                if (lat > 1) check_eq({tag, " busy"}, sel ? busy1 : busy0, 1'b1);
            end
        end while (!(sel ? done1 : done0) && edges < 40);
        check_eq({tag, " latency"}, edges, lat);
        check_eq({tag, " result"}, sel ? res1 : res0, exp_res);
        check_eq({tag, " err"}, sel ? err1 : err0, exp_err);
        check_eq({tag, " busy_at_done"}, sel ? busy1 : busy0, 1'b0);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check_eq({tag, " hold_done"}, sel ? done1 : done0, 1'b1);
            check_eq({tag, " hold_result"}, sel ? res1 : res0, exp_res);
        end
        @(negedge clk);
        go0 = 1'b0; go1 = 1'b0;
        @(posedge clk); #1;
        check_eq({tag, " idle_done"}, sel ? done1 : done0, 1'b0);
        check_eq({tag, " idle_result"}, sel ? res1 : res0, exp_res);
    endtask

    initial begin
        logic [0:31][7:0] part;
        reset = 1'b1; go0 = 1'b0; go1 = 1'b0; index = '0; A = '0; B = '0;
        repeat (2) @(negedge clk);
        check_eq("rst busy", busy0, 1'b0);
        check_eq("rst done", done0, 1'b0);
        check_eq("rst err", err0, 1'b0);
        check_eq("rst result", res0, '0);
        reset = 1'b0;

        run_op("cmp_lt",     0, 4'd0, s2b("abc"), s2b("abd"), 2, b0(8'hFF), 1'b0, 0);
        run_op("upper",      0, 4'd1, s2b("Hello, World!"), '0, 5, s2b("HELLO, WORLD!"), 1'b0, 0);
        run_op("lower",      0, 4'd2, s2b("Hello, World!"), '0, 5, s2b("hello, world!"), 1'b0, 0);
        run_op("strlen32",   0, 4'd3, X32_LO, '0, 9, b0(8'd32), 1'b0, 0);
        run_op("strlen0",    0, 4'd3, '0, '0, 2, '0, 1'b0, 0);
        run_op("reverse",    0, 4'd4, s2b("abcde"), '0, 4, s2b("edcba"), 1'b0, 5);
        run_op("invalid",    0, 4'd9, s2b("abc"), '0, 1, '0, 1'b1, 0);
        run_op("cmp_eq",     0, 4'd0, s2b("ab"), s2b("ab"), 2, b0(8'h00), 1'b0, 0);
        run_op("cmp_gt",     0, 4'd0, s2b("b"), s2b("a"), 2, b0(8'h01), 1'b0, 0);
        run_op("cmp_full",   0, 4'd0, X32_LO, X32_LO, 9, b0(8'h00), 1'b0, 0);

        // asynchronous reset in the middle of a 32-byte toupper
        @(negedge clk);
        A = X32_LO; index = 4'd1; go0 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        part = '0;
        for (int i = 0; i < 8; i++) part[i] = 8'h58;
        check_eq("midrun busy", busy0, 1'b1);
        check_eq("midrun partial", res0, part);
        #2 reset = 1'b1;
        #1;
        check_eq("async_rst busy", busy0, 1'b0);
        check_eq("async_rst done", done0, 1'b0);
        check_eq("async_rst result", res0, '0);
        go0 = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        run_op("cmp_lanes1", 1, 4'd0, s2b("abc"), s2b("abd"), 4, b0(8'hFF), 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
